// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - four-slot write-back arbiter onto two register-file write ports
// Same-register ordering, round-robin fairness, x0 writes retired without a port.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid_i,
  input  logic [4*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [4*DATA_WIDTH-1:0] req_data_i,
  output logic [3:0]              req_ready_o,
  output logic                    wp0_en_o,
  output logic [ADDR_WIDTH-1:0]   wp0_addr_o,
  output logic [DATA_WIDTH-1:0]   wp0_data_o,
  output logic                    wp1_en_o,
  output logic [ADDR_WIDTH-1:0]   wp1_addr_o,
  output logic [DATA_WIDTH-1:0]   wp1_data_o,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

  logic [1:0]            r_rr_ptr;
  logic                  r_wp0_en;
  logic [ADDR_WIDTH-1:0] r_wp0_addr;
  logic [DATA_WIDTH-1:0] r_wp0_data;
  logic                  r_wp1_en;
  logic [ADDR_WIDTH-1:0] r_wp1_addr;
  logic [DATA_WIDTH-1:0] r_wp1_data;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [ADDR_WIDTH-1:0] w_addr [4];
  logic [DATA_WIDTH-1:0] w_data [4];
  logic [3:0]            w_x0;
  logic [3:0]            w_elig;
  logic [3:0]            w_grant;
  logic [1:0]            w_idx;
  logic [1:0]            w_first;
  logic [1:0]            w_second;
  logic [1:0]            w_ngrant;
  logic                  w_busy;

  // A younger slot waits while any older slot targets the same register.
  always_comb begin
    w_elig = '0;
    w_x0   = '0;
    for (int k = 0; k < 4; k++) begin
      w_addr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < 4; k++) begin
      w_x0[k]   = req_valid_i[k] && (w_addr[k] == '0);
      w_elig[k] = req_valid_i[k] && (w_addr[k] != '0);
      for (int j = 0; j < k; j++) begin
        if (req_valid_i[j] && (w_addr[j] == w_addr[k])) begin
          w_elig[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_grant  = '0;
    w_first  = '0;
    w_second = '0;
    w_ngrant = '0;
    w_idx    = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!rst && w_elig[w_idx] && (w_ngrant != 2'd2)) begin
        w_grant[w_idx] = 1'b1;
        if (w_ngrant == 2'd0) begin
          w_first = w_idx;
        end else begin
          w_second = w_idx;
        end
        w_ngrant = w_ngrant + 2'd1;
      end
    end
    w_busy = !rst && |(req_valid_i & ~w_x0 & ~w_grant);
  end

  assign req_ready_o = rst ? 4'b0000 : (w_grant | w_x0);
  assign busy_o      = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wp0_en   <= 1'b0;
      r_wp0_addr <= '0;
      r_wp0_data <= '0;
      r_wp1_en   <= 1'b0;
      r_wp1_addr <= '0;
      r_wp1_data <= '0;
      r_cnt      <= '0;
    end else begin
      r_wp0_en <= (w_ngrant != 2'd0);
      r_wp1_en <= (w_ngrant == 2'd2);
      if (w_ngrant != 2'd0) begin
        r_wp0_addr <= w_addr[w_first];
        r_wp0_data <= w_data[w_first];
      end
      // Pointer moves past the last slot granted this cycle.
      if (w_ngrant == 2'd2) begin
        r_wp1_addr <= w_addr[w_second];
        r_wp1_data <= w_data[w_second];
        r_rr_ptr   <= w_second + 2'd1;
      end else if (w_ngrant == 2'd1) begin
        r_rr_ptr   <= w_first + 2'd1;
      end
      if (w_busy && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign wp0_en_o       = r_wp0_en;
  assign wp0_addr_o     = r_wp0_addr;
  assign wp0_data_o     = r_wp0_data;
  assign wp1_en_o       = r_wp1_en;
  assign wp1_addr_o     = r_wp1_addr;
  assign wp1_data_o     = r_wp1_data;
  assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [19:0] req_addr_i  = '0;
  logic [127:0] req_data_i = '0;

  logic [3:0]  ready_a, ready_b;
  logic        wp0_en_a, wp1_en_a, wp0_en_b, wp1_en_b;
  logic [4:0]  wp0_addr_a, wp1_addr_a, wp0_addr_b, wp1_addr_b;
  logic [31:0] wp0_data_a, wp1_data_a, wp0_data_b, wp1_data_b;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int gcount [4];

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(ready_a),
    .wp0_en_o(wp0_en_a), .wp0_addr_o(wp0_addr_a), .wp0_data_o(wp0_data_a),
    .wp1_en_o(wp1_en_a), .wp1_addr_o(wp1_addr_a), .wp1_data_o(wp1_data_a),
    .busy_o(busy_a), .conflict_cnt_o(cnt_a)
  );

  rf_wb_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(ready_b),
    .wp0_en_o(wp0_en_b), .wp0_addr_o(wp0_addr_b), .wp0_data_o(wp0_data_b),
    .wp1_en_o(wp1_en_b), .wp1_addr_o(wp1_addr_b), .wp1_data_o(wp1_data_b),
    .busy_o(busy_b), .conflict_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid_i[k]        = v;
    req_addr_i[k*5 +: 5]  = a;
    req_data_i[k*32 +: 32] = d;
  endtask

  // Drive on the falling edge, then settle before checking combinational outputs.
  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, including ready/busy suppressed while rst is high.
    set_slot(0, 1'b1, 5'd3, 32'h1);
    after_posedge();
    after_posedge();
    drive_edge(); #1;
    check("rst_ready", ready_a, 4'b0000);
    check("rst_busy", busy_a, 1'b0);
    check("rst_wp0_en", wp0_en_a, 1'b0);
    check("rst_wp1_en", wp1_en_a, 1'b0);
    check("rst_wp0_addr", wp0_addr_a, 5'd0);
    check("rst_cnt", cnt_a, 16'd0);
    check("rst_ptr", dut.r_rr_ptr, 2'd0);
    set_slot(0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;

    // Single request on slot 2.
    drive_edge();
    set_slot(2, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    check("single_ready", ready_a, 4'b0100);
    check("single_busy", busy_a, 1'b0);
    after_posedge();
    check("single_wp0_en", wp0_en_a, 1'b1);
    check("single_wp0_addr", wp0_addr_a, 5'd7);
    check("single_wp0_data", wp0_data_a, 32'hDEADBEEF);
    check("single_wp1_en", wp1_en_a, 1'b0);
    check("single_ptr", dut.r_rr_ptr, 2'd3);
    drive_edge();
    set_slot(2, 1'b0, 5'd0, 32'h0);
    after_posedge();
    check("idle_wp0_en", wp0_en_a, 1'b0);
    check("idle_wp0_addr_hold", wp0_addr_a, 5'd7);

    // Re-reset so the pointer starts at 0 for contention.
    drive_edge();
    rst = 1'b1;
    after_posedge();
    drive_edge();
    rst = 1'b0;
    set_slot(0, 1'b1, 5'd1, 32'hA1);
    set_slot(1, 1'b1, 5'd2, 32'hA2);
    set_slot(2, 1'b1, 5'd3, 32'hA3);
    set_slot(3, 1'b1, 5'd4, 32'hA4);
    #1;
    check("four_c0_ready", ready_a, 4'b0011);
    check("four_c0_busy", busy_a, 1'b1);
    after_posedge();
    check("four_c0_wp0", {wp0_en_a, wp0_addr_a, wp0_data_a}, {1'b1, 5'd1, 32'hA1});
    check("four_c0_wp1", {wp1_en_a, wp1_addr_a, wp1_data_a}, {1'b1, 5'd2, 32'hA2});
    check("four_c0_cnt", cnt_a, 16'd1);
    drive_edge();
    set_slot(0, 1'b0, 5'd0, 32'h0);
    set_slot(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("four_c1_ready", ready_a, 4'b1100);
    check("four_c1_busy", busy_a, 1'b0);
    after_posedge();
    check("four_c1_wp0", {wp0_en_a, wp0_addr_a, wp0_data_a}, {1'b1, 5'd3, 32'hA3});
    check("four_c1_wp1", {wp1_en_a, wp1_addr_a, wp1_data_a}, {1'b1, 5'd4, 32'hA4});
    check("four_c1_cnt", cnt_a, 16'd1);
    check("four_ptr", dut.r_rr_ptr, 2'd0);

    // Ordering conflict: slot 3 must land after slot 0 on the same register.
    drive_edge();
    set_slot(2, 1'b0, 5'd0, 32'h0);
    set_slot(0, 1'b1, 5'd9, 32'h11);
    set_slot(3, 1'b1, 5'd9, 32'h22);
    #1;
    check("ord_c0_ready", ready_a, 4'b0001);
    check("ord_c0_busy", busy_a, 1'b1);
    after_posedge();
    check("ord_c0_wp0", {wp0_en_a, wp0_addr_a, wp0_data_a}, {1'b1, 5'd9, 32'h11});
    check("ord_c0_wp1_en", wp1_en_a, 1'b0);
    check("ord_c0_cnt", cnt_a, 16'd2);
    drive_edge();
    set_slot(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("ord_c1_ready", ready_a, 4'b1000);
    after_posedge();
    check("ord_c1_wp0", {wp0_en_a, wp0_addr_a, wp0_data_a}, {1'b1, 5'd9, 32'h22});
    check("ord_ptr", dut.r_rr_ptr, 2'd0);

    // x0 requests retire without a port.
    drive_edge();
    set_slot(0, 1'b1, 5'd0, 32'hF0);
    set_slot(1, 1'b1, 5'd0, 32'hF1);
    set_slot(2, 1'b1, 5'd5, 32'h55);
    set_slot(3, 1'b1, 5'd6, 32'h66);
    #1;
    check("x0_ready", ready_a, 4'b1111);
    check("x0_busy", busy_a, 1'b0);
    after_posedge();
    check("x0_wp0", {wp0_en_a, wp0_addr_a, wp0_data_a}, {1'b1, 5'd5, 32'h55});
    check("x0_wp1", {wp1_en_a, wp1_addr_a, wp1_data_a}, {1'b1, 5'd6, 32'h66});
    check("x0_cnt", cnt_a, 16'd2);

    // Fairness: slots 0..2 always valid, pointer starts at 0.
    drive_edge();
    set_slot(0, 1'b1, 5'd10, 32'h100);
    set_slot(1, 1'b1, 5'd11, 32'h101);
    set_slot(2, 1'b1, 5'd12, 32'h102);
    set_slot(3, 1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      logic [3:0] exp_r;
      case (c % 3)
        0:       exp_r = 4'b0011;
        1:       exp_r = 4'b0101;
        default: exp_r = 4'b0110;
      endcase
      #1;
      check($sformatf("fair_c%0d_ready", c), ready_a, exp_r);
      for (int k = 0; k < 4; k++) if (ready_a[k]) gcount[k]++;
      drive_edge();
    end
    check("fair_g0", gcount[0], 4);
    check("fair_g1", gcount[1], 4);
    check("fair_g2", gcount[2], 4);
    check("fair_cnt", cnt_a, 16'd8);

    // Reset mid-contention.
    rst = 1'b1;
    #1;
    check("midrst_ready", ready_a, 4'b0000);
    check("midrst_busy", busy_a, 1'b0);
    after_posedge();
    check("midrst_en", {wp0_en_a, wp1_en_a}, 2'b00);
    check("midrst_cnt", cnt_a, 16'd0);
    check("midrst_ptr", dut.r_rr_ptr, 2'd0);
    drive_edge();
    rst = 1'b0;

    // Saturation: 20 busy cycles with three contending slots.
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 14) check("sat_busy_c14", busy_b, 1'b1);
      after_posedge();
      if (c == 14) check("sat_cnt4_at15", cnt_b, 4'd15);
      drive_edge();
    end
    check("sat_cnt4_hold", cnt_b, 4'd15);
    check("sat_cnt16", cnt_a, 16'd20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
